// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - 640x480@60 VGA raster timing generator; VGA_SYNC_DELAY_EN adds 2-clock sync/blank delay
module vga_timing_generator #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_TOTAL      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_TOTAL      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       x_last;
  logic       y_last;
  logic       line_wrap;
  logic       frame_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hsync_dec;
  logic       vsync_dec;
  logic       video_dec;

  // Next counter values; decode uses these so outputs line up with the x/y they describe
  always_comb begin
    x_last     = (x == H_TOTAL - 10'd1);
    y_last     = (y == V_TOTAL - 10'd1);
    line_wrap  = pix_tick & x_last;
    frame_wrap = line_wrap & y_last;
    x_next     = x;
    y_next     = y;
    if (pix_tick) x_next = x_last ? 10'd0 : x + 10'd1;
    if (line_wrap) y_next = y_last ? 10'd0 : y + 10'd1;
  end

  // Counters, single-clock strobes and registered sync/blank decode (decode holds between ticks)
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync_dec   <= ~SYNC_ACTIVE;
      vsync_dec   <= ~SYNC_ACTIVE;
      video_dec   <= 1'b0;
    end else begin
      x           <= x_next;
      y           <= y_next;
      line_start  <= line_wrap;
      frame_start <= frame_wrap;
      if (frame_wrap) frame_count <= frame_count + 8'd1;
      if (pix_tick) begin
        hsync_dec <= (x_next >= H_SYNC_START && x_next < H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_dec <= (y_next >= V_SYNC_START && y_next < V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_dec <= (x_next < H_VIS) && (y_next < V_VIS);
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [1:0] hsync_pipe;
  logic [1:0] vsync_pipe;
  logic [1:0] video_pipe;

  // Two-stage delay matching the pixel pipeline latency downstream; shifts every clock
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      hsync_pipe <= {2{~SYNC_ACTIVE}};
      vsync_pipe <= {2{~SYNC_ACTIVE}};
      video_pipe <= 2'b00;
    end else begin
      hsync_pipe <= {hsync_pipe[0], hsync_dec};
      vsync_pipe <= {vsync_pipe[0], vsync_dec};
      video_pipe <= {video_pipe[0], video_dec};
    end
  end

  assign hsync    = hsync_pipe[1];
  assign vsync    = vsync_pipe[1];
  assign video_on = video_pipe[1];
`else
  assign hsync    = hsync_dec;
  assign vsync    = vsync_dec;
  assign video_on = video_dec;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - directed self-checking bench for vga_timing_generator
module tb_vga_timing_generator;

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hs, d_vs, d_vo, d_ls, d_fs;
  logic       s_hs, s_vs, s_vo, s_ls, s_fs;
  logic [7:0] d_fc, s_fc;

  int n_cmp = 0;
  int n_bad = 0;

  int hs_low, npulse, p0, p1, wrapped;
  int xm, ym, fcm, fs_cnt, last_fs, vs_low, lw, fw, guard;
  int eh[0:599];
  int ev[0:599];
  int eo[0:599];

  always #5 clk = ~clk;

  vga_timing_generator dut (
    .vga_clk(clk), .rst_n(rst_n), .pix_tick(tick),
    .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  // Reduced raster: 16 x 10 total, so whole frames fit in a short run
  vga_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
  ) sm (
    .vga_clk(clk), .rst_n(rst_n), .pix_tick(tick),
    .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset overrides pix_tick
    rst_n = 1'b0; tick = 1'b1;
    step(); step();
    chk("rst_x", d_x, 0); chk("rst_y", d_y, 0); chk("rst_hs", d_hs, 1); chk("rst_vs", d_vs, 1);
    chk("rst_vo", d_vo, 0); chk("rst_ls", d_ls, 0); chk("rst_fs", d_fs, 0); chk("rst_fc", d_fc, 0);

    // Reset exit with pix_tick low: counters and video_on hold
    rst_n = 1'b1; tick = 1'b0;
    step();
    chk("hold_x", d_x, 0); chk("hold_vo", d_vo, 0); chk("hold_ls", d_ls, 0);
    tick = 1'b1;
    step();
    chk("first_x", d_x, 1); chk("first_y", d_y, 0);
`ifndef VGA_SYNC_DELAY_EN
    chk("first_vo", d_vo, 1);
`endif

    // First line with pix_tick tied high
    hs_low = 0;
    for (int i = 2; i < 800; i++) begin
      step();
      chk("run_x", d_x, i);
      chk("run_ls", d_ls, 0);
      if (d_hs == 1'b0) hs_low++;
      if (i >= DLY + 1) begin
        chk("run_hs", d_hs, ((i - DLY) >= 656 && (i - DLY) < 752) ? 0 : 1);
        chk("run_vo", d_vo, ((i - DLY) < 640) ? 1 : 0);
      end
    end
    chk("hs_low_cycles", hs_low, 96);
    step();
    chk("wrap_x", d_x, 0); chk("wrap_y", d_y, 1); chk("wrap_ls", d_ls, 1); chk("wrap_fs", d_fs, 0);
    step();
    chk("post_wrap_x", d_x, 1); chk("post_wrap_ls", d_ls, 0);

    // pix_tick alternating: one count per two clocks, single-clock line strobe
    xm = 1; ym = 1; npulse = 0; p0 = 0; p1 = 0;
    for (int c = 0; c < 3200; c++) begin
      tick = (c % 2 == 0);
      step();
      wrapped = 0;
      if (tick) begin
        if (xm == 799) begin xm = 0; ym++; wrapped = 1; end
        else xm++;
      end
      chk("tog_x", d_x, xm);
      chk("tog_ls", d_ls, wrapped);
      if (d_ls) begin
        if (npulse == 0) p0 = c; else p1 = c;
        npulse++;
      end
    end
    chk("tog_npulse", npulse, 2);
    chk("tog_period", p1 - p0, 1600);
    chk("tog_y", d_y, ym);

    // Whole frames on the reduced raster
    tick = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("srst_x", s_x, 0); chk("srst_vs", s_vs, 1); chk("srst_fc", s_fc, 0);
    xm = 0; ym = 0; fcm = 0; fs_cnt = 0; last_fs = -1; vs_low = 0;
    for (int c = 0; c < 500; c++) begin
      step();
      lw = 0; fw = 0;
      if (xm == 15) begin
        xm = 0; lw = 1;
        if (ym == 9) begin ym = 0; fw = 1; fcm = (fcm + 1) % 256; end
        else ym++;
      end else xm++;
      eh[c] = (xm >= 10 && xm < 13) ? 0 : 1;
      ev[c] = (ym >= 7 && ym < 9) ? 0 : 1;
      eo[c] = (xm < 8 && ym < 6) ? 1 : 0;
      chk("f_x", s_x, xm); chk("f_y", s_y, ym);
      chk("f_ls", s_ls, lw); chk("f_fs", s_fs, fw); chk("f_fc", s_fc, fcm);
      chk("f_hs", s_hs, (c >= DLY) ? eh[c - DLY] : 1);
      chk("f_vs", s_vs, (c >= DLY) ? ev[c - DLY] : 1);
      chk("f_vo", s_vo, (c >= DLY) ? eo[c - DLY] : 0);
`ifndef VGA_SYNC_DELAY_EN
      if (xm == 7 && ym == 5) chk("vo_edge_7_5", s_vo, 1);
      if (xm == 8 && ym == 5) chk("vo_edge_8_5", s_vo, 0);
      if (xm == 0 && ym == 6) chk("vo_edge_0_6", s_vo, 0);
      if (xm == 0 && ym == 0) chk("vo_edge_0_0", s_vo, 1);
`endif
      if (s_fs) begin
        if (last_fs >= 0) chk("fs_period", c - last_fs, 160);
        last_fs = c;
        fs_cnt++;
      end
      if (s_vs == 1'b0) vs_low++;
    end
    chk("fs_count", fs_cnt, 3);
    chk("fc_final", s_fc, 3);
    chk("vs_low_cycles", vs_low, 96);

    // Run to (4,3) inside the active area, then reset for one edge
    guard = 0;
    while (!(xm == 4 && ym == 3) && guard < 200) begin
      step();
      guard++;
      if (xm == 15) begin xm = 0; ym = (ym == 9) ? 0 : ym + 1; end
      else xm++;
    end
    chk("reach_bound", (guard < 200) ? 1 : 0, 1);
    chk("pre_rst_x", s_x, 4); chk("pre_rst_y", s_y, 3); chk("pre_rst_vo", s_vo, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_x", s_x, 0); chk("mrst_y", s_y, 0); chk("mrst_vo", s_vo, 0);
    chk("mrst_hs", s_hs, 1); chk("mrst_vs", s_vs, 1); chk("mrst_fc", s_fc, 0);
    chk("mrst_fs", s_fs, 0); chk("mrst_ls", s_ls, 0); chk("mrst_dfc", d_fc, 0);
    step();
    chk("mrst_exit_x", s_x, 1); chk("mrst_exit_fs", s_fs, 0); chk("mrst_exit_ls", s_ls, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
